// File: rtl/my_fifo_pkg.sv
// Shared defaults and helpers for the my_fifo single-clock FIFO.
package my_fifo_pkg;

  localparam int unsigned DEFAULT_BIT_DEPTH  = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

  // Encoded as {push, pop} so the decode can be built directly from the two qualifiers.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/my_fifo_ram.sv
// FIFO storage array: synchronous write, combinational read. Contents are never reset.
module my_fifo_ram
  import my_fifo_pkg::*;
#(
  parameter int unsigned BIT_DEPTH  = DEFAULT_BIT_DEPTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned ADDR_W     = clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [BIT_DEPTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [BIT_DEPTH-1:0] rdata_o
);

  logic [BIT_DEPTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/my_fifo.sv
// Single-clock synchronous FIFO with registered read data.
// Optional MY_FIFO_LEVEL_EN adds the level and almost_full outputs.
module my_fifo
  import my_fifo_pkg::*;
#(
  parameter  int unsigned BIT_DEPTH  = DEFAULT_BIT_DEPTH,
  parameter  int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int unsigned ADDR_W     = clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_read,
  input  logic                 enable_write,
  input  logic [BIT_DEPTH-1:0] value_to_write,
  output logic [BIT_DEPTH-1:0] value_to_read,
  output logic                 full,
  output logic                 empty
`ifdef MY_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]      level,
  output logic                 almost_full
`endif
);

  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [BIT_DEPTH-1:0] value_to_read_q, value_to_read_d;
  logic [BIT_DEPTH-1:0] ram_rdata;
  logic                 do_push, do_pop;
  fifo_op_e             op;

  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);

  // A push into a full FIFO is accepted when a pop frees the oldest slot on the same edge.
  assign do_pop  = enable_read && !empty;
  assign do_push = enable_write && (!full || do_pop);
  assign op      = fifo_op_e'({do_push, do_pop});

  my_fifo_ram #(
    .BIT_DEPTH  (BIT_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (value_to_write),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    value_to_read_d = value_to_read_q;
    case (op)
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      OP_POP: begin
        rd_ptr_d        = rd_ptr_q + 1'b1;
        count_d         = count_q - 1'b1;
        value_to_read_d = ram_rdata;
      end
      OP_BOTH: begin
        wr_ptr_d        = wr_ptr_q + 1'b1;
        rd_ptr_d        = rd_ptr_q + 1'b1;
        value_to_read_d = ram_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      value_to_read_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      value_to_read_q <= value_to_read_d;
    end
  end

  assign value_to_read = value_to_read_q;

`ifdef MY_FIFO_LEVEL_EN
  assign level       = count_q;
  assign almost_full = (count_q >= COUNT_FULL - 1'b1);
`endif

endmodule

// File: tb/tb_my_fifo.sv
// Directed self-checking bench for my_fifo in its default configuration.
module tb_my_fifo;

  logic       clk;
  logic       rst;
  logic       enable_read;
  logic       enable_write;
  logic [7:0] value_to_write;
  logic [7:0] value_to_read;
  logic       full;
  logic       empty;

  int unsigned n_checks;
  int unsigned n_fail;

  my_fifo #(
    .BIT_DEPTH  (8),
    .FIFO_DEPTH (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_read    (enable_read),
    .enable_write   (enable_write),
    .value_to_write (value_to_write),
    .value_to_read  (value_to_read),
    .full           (full),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    enable_write   = 1'b1;
    value_to_write = v;
    step();
    enable_write   = 1'b0;
  endtask

  task automatic pop();
    enable_read = 1'b1;
    step();
    enable_read = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    enable_read    = 1'b0;
    enable_write   = 1'b0;
    value_to_write = '0;

    // Reset held, then released
    repeat (5) step();
    check("rst_vtr",   value_to_read, 0);
    check("rst_empty", empty, 1);
    check("rst_full",  full, 0);
    rst = 1'b0;
    step();
    check("rel_vtr",   value_to_read, 0);
    check("rel_empty", empty, 1);
    check("rel_full",  full, 0);

    // Single write then read
    push(8'd7);
    check("w7_empty", empty, 0);
    pop();
    check("r7_vtr",   value_to_read, 7);
    check("r7_empty", empty, 1);

    // Simultaneous read/write with one word queued
    push(8'd7);
    enable_write   = 1'b1;
    value_to_write = 8'd12;
    enable_read    = 1'b1;
    step();
    enable_write   = 1'b0;
    enable_read    = 1'b0;
    check("rw_vtr",   value_to_read, 7);
    check("rw_empty", empty, 0);
    check("rw_full",  full, 0);
    pop();
    check("rw_r12",       value_to_read, 12);
    check("rw_empty_end", empty, 1);

    // Fill to full, overflow drop, drain in order
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (i == 14) check("fill15_full", full, 0);
    end
    check("fill_full",  full, 1);
    check("fill_empty", empty, 0);
    push(8'd99);
    check("ovf_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      pop();
      check($sformatf("drain%0d", i), value_to_read, 32'(i));
    end
    check("drain_empty", empty, 1);
    check("drain_full",  full, 0);

    // Read while empty holds last value
    pop();
    pop();
    check("uflow_vtr",   value_to_read, 15);
    check("uflow_empty", empty, 1);
    push(8'd42);
    pop();
    check("uflow_ptr_vtr", value_to_read, 42);
    check("uflow_ptr_empty", empty, 1);

    // Simultaneous read/write on empty: write only, no bypass
    enable_write   = 1'b1;
    value_to_write = 8'd55;
    enable_read    = 1'b1;
    step();
    enable_write   = 1'b0;
    enable_read    = 1'b0;
    check("rwe_vtr",   value_to_read, 42);
    check("rwe_empty", empty, 0);
    pop();
    check("rwe_r55", value_to_read, 55);

    // Simultaneous read/write on full: oldest out, new word stored
    for (int i = 0; i < 16; i++) push(8'(16 + i));
    check("rwf_pre_full", full, 1);
    enable_write   = 1'b1;
    value_to_write = 8'd200;
    enable_read    = 1'b1;
    step();
    enable_write   = 1'b0;
    enable_read    = 1'b0;
    check("rwf_vtr",  value_to_read, 16);
    check("rwf_full", full, 1);
    for (int i = 0; i < 15; i++) begin
      pop();
      check($sformatf("rwf_drain%0d", i), value_to_read, 32'(17 + i));
    end
    pop();
    check("rwf_new",   value_to_read, 200);
    check("rwf_empty", empty, 1);

    // Asynchronous reset mid-operation
    push(8'd1);
    push(8'd2);
    push(8'd3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_empty", empty, 1);
    check("arst_full",  full, 0);
    check("arst_vtr",   value_to_read, 0);
    step();
    rst = 1'b0;
    step();
    check("arst_rel_empty", empty, 1);
    push(8'd5);
    pop();
    check("arst_r5",       value_to_read, 5);
    check("arst_end_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
